pe_psum_accum_ctrl: RTL

//  Downstream of the PE buffer/array stage: consumes the Iw x Wh partial-sum lanes produced by the PE array,

---
 rtl/pe_psum_accum_ctrl_pkg.sv | 18 +
 rtl/pe_psum_accum_ctrl_if.sv | 29 ++
 rtl/pe_psum_accum_ctrl_ram.sv | 21 ++
 rtl/pe_psum_accum_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pe_psum_accum_ctrl_pkg.sv
// pe_psum_accum_ctrl_pkg: shared default sizes, beat/word types and FSM states.
// No ports; imported by the interface, the RAM and the controller top.
package pe_psum_accum_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PSUM_WIDTH = 2 * DEF_DATA_WIDTH;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_IW         = 7;
    localparam int DEF_WH         = 2;
    localparam int DEF_HOUT       = 56;
    localparam int DEF_N          = 256;
    localparam int DEF_PASSES     = 32;
    localparam int DEF_SHIFT      = 8;
    localparam int DEF_DEPTH      = (DEF_HOUT / DEF_IW) * (DEF_N / DEF_WH);
    localparam int DEF_AW         = $clog2(DEF_DEPTH);
    typedef logic [DEF_IW-1:0][DEF_WH-1:0][DEF_PSUM_WIDTH-1:0] psum_beat_t;
    typedef logic [DEF_IW-1:0][DEF_WH-1:0][DEF_ACC_WIDTH-1:0]  acc_word_t;
    typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_DRAIN} state_t;
endpackage

// File: rtl/pe_psum_accum_ctrl_if.sv
// pe_psum_accum_ctrl_if: partial-sum input beat and quantised result stream of the accumulator.
// Signals: psum_in/psum_valid (no backpressure), acc_out/out_addr/out_valid/out_ready result handshake,
// ram_output_blocked upstream stall, layer_done pulse, err_psum_in_drain sticky error.
// master = producer/consumer environment, slave = pe_psum_accum_ctrl.
interface pe_psum_accum_ctrl_if import pe_psum_accum_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int Iw         = DEF_IW,
    parameter int Wh         = DEF_WH,
    parameter int AW         = DEF_AW
);
    logic [Iw-1:0][Wh-1:0][PSUM_WIDTH-1:0] psum_in;
    logic                                  psum_valid;
    logic [Iw-1:0][Wh-1:0][DATA_WIDTH-1:0] acc_out;
    logic [AW-1:0]                         out_addr;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  ram_output_blocked;
    logic                                  layer_done;
    logic                                  err_psum_in_drain;
    modport master (
        output psum_in, psum_valid, out_ready,
        input  acc_out, out_addr, out_valid, ram_output_blocked, layer_done, err_psum_in_drain
    );
    modport slave (
        input  psum_in, psum_valid, out_ready,
        output acc_out, out_addr, out_valid, ram_output_blocked, layer_done, err_psum_in_drain
    );
endinterface

// File: rtl/pe_psum_accum_ctrl_ram.sv
// pe_psum_accum_ctrl_ram: simple dual-port accumulation RAM, one write port and one registered read port.
// Ports: clk; we_i/waddr_i/wdata_i write; re_i/raddr_i read request; rdata_o valid the cycle after re_i.
module pe_psum_accum_ctrl_ram #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end
endmodule

// File: rtl/pe_psum_accum_ctrl.sv
// pe_psum_accum_ctrl: accumulates PASSES partial-sum passes per tile in RAM, then drains ReLU'd requantised words.
// Ports: clk, rstn (async, active-low); bus (slave) carries psum input beats, the result stream with
// ready/valid, ram_output_blocked, layer_done and the sticky err_psum_in_drain flag.
module pe_psum_accum_ctrl import pe_psum_accum_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int Iw         = DEF_IW,
    parameter int Wh         = DEF_WH,
    parameter int HOUT       = DEF_HOUT,
    parameter int N          = DEF_N,
    parameter int PASSES     = DEF_PASSES,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int DEPTH      = (HOUT / Iw) * (N / Wh),
    parameter int AW         = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                rstn,
    pe_psum_accum_ctrl_if.slave bus
);
    localparam int W   = Iw * Wh * ACC_WIDTH;
    localparam int PCW = $clog2(PASSES + 1);
    localparam logic [DATA_WIDTH-1:0] QMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    state_t                                     state_q, state_d;
    logic [AW-1:0]                              wr_addr_q, wr_addr_d, waddr_q, pend_addr_q;
    logic [PCW-1:0]                             pass_cnt_q, pass_cnt_d;
    logic [AW:0]                                rd_cnt_q, rd_cnt_d;
    logic [1:0]                                 cnt_q, cnt_d;
    logic                                       wv_q, first_q, err_q, rd_pend_q, wp_q, rp_q;
    logic [Iw-1:0][Wh-1:0][PSUM_WIDTH-1:0]      psum_q;
    logic [1:0][AW-1:0]                         fa_q;
    logic [1:0][Iw-1:0][Wh-1:0][DATA_WIDTH-1:0] fd_q;
    logic [Iw-1:0][Wh-1:0][ACC_WIDTH-1:0]       rd_word, wr_word;
    logic [Iw-1:0][Wh-1:0][DATA_WIDTH-1:0]      q_word;
    logic                                       beat, wrap, issue, pop, last;

    // Sum in ACC_WIDTH+1 bits; differing top two bits mean overflow, clamp toward the sign.
    function automatic logic [ACC_WIDTH-1:0] sat_add(logic [ACC_WIDTH-1:0] a, logic [PSUM_WIDTH-1:0] p);
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
        return s[ACC_WIDTH] == s[ACC_WIDTH-1] ? s[ACC_WIDTH-1:0] : {s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] quant(logic [ACC_WIDTH-1:0] a);
        logic [ACC_WIDTH-1:0] s;
        s = a >> SHIFT;
        return a[ACC_WIDTH-1] ? '0 : (s > ACC_WIDTH'(QMAX) ? QMAX : s[DATA_WIDTH-1:0]);
    endfunction

    assign beat  = bus.psum_valid && state_q == ST_ACC;
    assign wrap  = wr_addr_q == AW'(DEPTH - 1);
    assign pop   = bus.out_valid && bus.out_ready;
    assign last  = pop && bus.out_addr == AW'(DEPTH - 1);
    // A read may issue only if its data is guaranteed a skid slot when it lands next cycle.
    assign issue = state_q == ST_DRAIN && rd_cnt_q < (AW+1)'(DEPTH)
                   && int'(cnt_q) + int'(rd_pend_q) - int'(pop) < 2;

    pe_psum_accum_ctrl_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (wv_q),
        .waddr_i (waddr_q),
        .wdata_i (wr_word),
        .re_i    (beat || issue),
        .raddr_i (beat ? wr_addr_q : rd_cnt_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    always_comb begin
        wr_word = '0;
        q_word  = '0;
        for (int i = 0; i < Iw; i++)
            for (int j = 0; j < Wh; j++) begin
                wr_word[i][j] = sat_add(first_q ? '0 : rd_word[i][j], psum_q[i][j]);
                q_word[i][j]  = quant(rd_word[i][j]);
            end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = beat ? (wrap ? '0 : wr_addr_q + AW'(1)) : wr_addr_q;
        pass_cnt_d = pass_cnt_q;
        rd_cnt_d   = rd_cnt_q + (AW+1)'(issue);
        cnt_d      = cnt_q + 2'(rd_pend_q) - 2'(pop);
        if (beat && wrap) begin
            pass_cnt_d = pass_cnt_q == PCW'(PASSES - 1) ? '0 : pass_cnt_q + PCW'(1);
            state_d    = pass_cnt_q == PCW'(PASSES - 1) ? ST_FLUSH : ST_ACC;
        end
        if (state_q == ST_FLUSH) state_d = ST_DRAIN;
        if (last) begin
            state_d  = ST_ACC;
            rd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ACC;
            wr_addr_q   <= '0;
            pass_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            cnt_q       <= '0;
            wv_q        <= 1'b0;
            waddr_q     <= '0;
            first_q     <= 1'b0;
            psum_q      <= '0;
            err_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            pend_addr_q <= '0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            fa_q        <= '0;
            fd_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            pass_cnt_q <= pass_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            cnt_q      <= cnt_d;
            wv_q       <= beat;
            rd_pend_q  <= issue;
            err_q      <= err_q || (bus.psum_valid && state_q != ST_ACC);
            if (beat) begin
                waddr_q <= wr_addr_q;
                first_q <= pass_cnt_q == '0;
                psum_q  <= bus.psum_in;
            end
            if (issue) pend_addr_q <= rd_cnt_q[AW-1:0];
            if (rd_pend_q) begin
                fd_q[wp_q] <= q_word;
                fa_q[wp_q] <= pend_addr_q;
                wp_q       <= ~wp_q;
            end
            if (pop) rp_q <= ~rp_q;
        end
    end

    assign bus.acc_out            = fd_q[rp_q];
    assign bus.out_addr           = fa_q[rp_q];
    assign bus.out_valid          = cnt_q != 2'd0;
    assign bus.ram_output_blocked = state_q != ST_ACC;
    assign bus.layer_done         = last;
    assign bus.err_psum_in_drain  = err_q;
endmodule
